// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command frame decoder.
// Frame layout depends on UART_CMD_CHECKSUM_EN (adds a trailing XOR byte).
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame lengths include the SYNC byte.
  localparam int unsigned FRAME_LEN_CHK   = 5;
  localparam int unsigned FRAME_LEN_NOCHK = 4;

`ifdef UART_CMD_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_ISSUE
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] op,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return op ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Decoded-command valid/ready port; master = decoder, slave = consumer.
interface uart_cmd_decoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_decoder_sink.sv
// uart_byte_sink: rxvalid/rxack level handshake with a one-cycle capture strobe.
// Reusable by any consumer sitting behind the UART receiver.
module uart_byte_sink (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] rxdata,
  input  logic       rxvalid,
  output logic       rxack,
  output logic       take,
  output logic [7:0] byte_data
);

  // A byte is taken only while rxack is low, so a held rxvalid yields one capture.
  assign take      = en && rxvalid && !rxack;
  assign byte_data = rxdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxack <= 1'b0;
    end else if (take) begin
      rxack <= 1'b1;
    end else if (rxack && !rxvalid) begin
      rxack <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles [SYNC][CMD][ADDR][DATA]{[CHK]} byte frames into one command word.
// Define UART_CMD_CHECKSUM_EN to require the trailing XOR checksum byte.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rxdata,
  input  logic                 rxvalid,
  output logic                 rxack,
  uart_cmd_decoder_if.master   cmd,
  output logic [ERRCNT_W-1:0]  err_count,
  output logic                 busy
);

  localparam int unsigned   TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMAX = TMR_W'(TIMEOUT_CYC - 1);

  state_t            state, state_d;
  logic [TMR_W-1:0]  timer, timer_d;
  logic [7:0]        op_q, addr_q, data_q;
  logic              ld_op, ld_addr, ld_data, err_inc;
  logic              take_en, take, in_frame, timed_out;
  logic [7:0]        rx_byte;

  assign take_en = (state != S_ISSUE);

  uart_byte_sink u_sink (
    .clk       (clk),
    .rst       (rst),
    .en        (take_en),
    .rxdata    (rxdata),
    .rxvalid   (rxvalid),
    .rxack     (rxack),
    .take      (take),
    .byte_data (rx_byte)
  );

  assign in_frame  = (state == S_CMD) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_CHK);
  assign timed_out = in_frame && (timer == TMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HUNT;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    ld_op   = 1'b0;
    ld_addr = 1'b0;
    ld_data = 1'b0;
    err_inc = 1'b0;

    if (in_frame) begin
      timer_d = timer + 1'b1;
    end

    case (state)
      S_HUNT:  if (take && rx_byte == SYNC_BYTE) state_d = S_CMD;
      S_CMD:   if (take) begin ld_op   = 1'b1; state_d = S_ADDR; end
      S_ADDR:  if (take) begin ld_addr = 1'b1; state_d = S_DATA; end
      S_DATA:  if (take) begin
        ld_data = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
        state_d = S_CHK;
`else
        state_d = S_ISSUE;
`endif
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CHK:   if (take) begin
        if (rx_byte == frame_chk(op_q, addr_q, data_q)) begin
          state_d = S_ISSUE;
        end else begin
          err_inc = 1'b1;
          state_d = S_HUNT;
        end
      end
`endif
      S_ISSUE: if (cmd.cmd_ready) state_d = S_HUNT;
      default: state_d = S_HUNT;
    endcase

    // A capture on the expiry cycle keeps the frame alive and restarts the timer.
    if (take) begin
      timer_d = '0;
    end else if (timed_out) begin
      timer_d = '0;
      err_inc = 1'b1;
      state_d = S_HUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_count <= '0;
    end else begin
      timer <= timer_d;
      if (ld_op)   op_q   <= rx_byte;
      if (ld_addr) addr_q <= rx_byte;
      if (ld_data) data_q <= rx_byte;
      if (err_inc && err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  assign cmd.cmd_valid = (state == S_ISSUE);
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_data  = data_q;
  assign busy          = (state != S_HUNT);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder; frames carry a checksum byte when
// UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_decoder;

  localparam int unsigned TO   = 64;
  localparam int unsigned ERRW = 2;
  localparam int          EMAX = (1 << ERRW) - 1;
  localparam int          WAIT_MAX = 200;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rxdata = '0;
  logic            rxvalid = 1'b0;
  logic            rxack;
  logic [ERRW-1:0] err_count;
  logic            busy;

  uart_cmd_decoder_if cmd_if ();

  uart_cmd_decoder #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TO),
    .ERRCNT_W    (ERRW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxdata    (rxdata),
    .rxvalid   (rxvalid),
    .rxack     (rxack),
    .cmd       (cmd_if.master),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_cmd  = 0;
  int          exp_cmd = 0;
  int          exp_err = 0;
  logic [23:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bump_err();
    exp_err = (exp_err < EMAX) ? exp_err + 1 : EMAX;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rxdata  = b;
    rxvalid = 1'b1;
    n = 0;
    while (!rxack && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) chk("ack_timeout", 32'(rxack), 32'd1);
    rxvalid = 1'b0;
    n = 0;
    while (rxack && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) chk("ack_release_timeout", 32'(rxack), 32'd0);
  endtask

  task automatic send_body(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
    send_byte(op);
    send_byte(addr);
    send_byte(data);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(op ^ addr ^ data);
`endif
  endtask

  task automatic good_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data);
    sb.push_back({op, addr, data});
    exp_cmd++;
    send_byte(8'hA5);
    send_body(op, addr, data);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every accepted command.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        n_cmd++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_cmd: got %0h expected none",
                   {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data});
        end else begin
          e = sb.pop_front();
          chk("cmd_fields", 32'({cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    int rises, viol, n;
    logic prev;
    logic [23:0] snap;

    cmd_if.cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("rst_ack",   32'(rxack), 32'd0);
    chk("rst_err",   32'(err_count), 32'd0);
    rst = 1'b0;

    // 1: basic frame
    good_frame(8'h10, 8'h20, 8'h30);
    chk("t1_err",  32'(err_count), 32'(exp_err));
    chk("t1_ncmd", 32'(n_cmd), 32'(exp_cmd));

    // Held rxvalid must produce a single capture (SYNC held for 10 cycles).
    sb.push_back(24'h102030);
    exp_cmd++;
    @(negedge clk);
    rxdata = 8'hA5;
    rxvalid = 1'b1;
    rises = 0;
    prev = rxack;
    repeat (10) begin
      @(negedge clk);
      if (rxack && !prev) rises++;
      prev = rxack;
    end
    rxvalid = 1'b0;
    n = 0;
    while (rxack && n < WAIT_MAX) begin @(negedge clk); n++; end
    chk("hold_single_capture", 32'(rises), 32'd1);
    send_body(8'h10, 8'h20, 8'h30);
    repeat (3) @(negedge clk);

    // 2: noise before a frame
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk("t2_noise_busy", 32'(busy), 32'd0);
    good_frame(8'hC3, 8'h5A, 8'hA5);
    chk("t2_err", 32'(err_count), 32'(exp_err));

`ifdef UART_CMD_CHECKSUM_EN
    // 3: bad checksum drops the frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'hFF);
    bump_err();
    repeat (2) @(negedge clk);
    chk("t3_err", 32'(err_count), 32'(exp_err));
    chk("t3_busy", 32'(busy), 32'd0);
    good_frame(8'h01, 8'h02, 8'h03);
`endif

    // 4: inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO - 8) @(negedge clk);
    chk("t4_busy_before_expiry", 32'(busy), 32'd1);
    chk("t4_err_before_expiry", 32'(err_count), 32'(exp_err));
    repeat (16) @(negedge clk);
    bump_err();
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_err_after", 32'(err_count), 32'(exp_err));
    good_frame(8'h0F, 8'hF0, 8'h55);

    // 5: consumer backpressure stalls the byte path
    @(posedge clk); #1 cmd_if.cmd_ready = 1'b0;
    sb.push_back(24'h445566);
    exp_cmd++;
    send_byte(8'hA5);
    send_body(8'h44, 8'h55, 8'h66);
    @(negedge clk);
    rxdata = 8'hA5;
    rxvalid = 1'b1;
    snap = {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data};
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!cmd_if.cmd_valid || rxack ||
          {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} != snap) viol++;
    end
    chk("t5_stall_violations", 32'(viol), 32'd0);
    chk("t5_held_fields", 32'(snap), 32'h445566);
    @(posedge clk); #1 cmd_if.cmd_ready = 1'b1;
    n = 0;
    while (!rxack && n < WAIT_MAX) begin @(negedge clk); n++; end
    chk("t5_pending_acked", 32'(rxack), 32'd1);
    chk("t5_cmd_before_ack", 32'(n_cmd), 32'(exp_cmd));
    rxvalid = 1'b0;
    n = 0;
    while (rxack && n < WAIT_MAX) begin @(negedge clk); n++; end
    sb.push_back(24'h778899);
    exp_cmd++;
    send_body(8'h77, 8'h88, 8'h99);
    repeat (3) @(negedge clk);

    // err_count saturation through repeated timeouts
    repeat (3) begin
      send_byte(8'hA5);
      repeat (TO + 8) @(negedge clk);
      bump_err();
      chk("sat_err", 32'(err_count), 32'(exp_err));
    end

    // 6: asynchronous reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err_count), 32'd0);
    chk("t6_op", 32'(cmd_if.cmd_op), 32'd0);
    chk("t6_valid", 32'(cmd_if.cmd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    good_frame(8'hDE, 8'hAD, 8'h01);
    chk("t6_err_after", 32'(err_count), 32'(exp_err));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("cmd_count", 32'(n_cmd), 32'(exp_cmd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
